// File: rtl/mult_div_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit with HI/LO registers.
// One iteration per cycle; HI/LO update only on the edge that completes the last iteration.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH:0]   whi_q, whi_d;
  logic [WIDTH-1:0] wlo_q, wlo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH:0]   iter_hi;
  logic [WIDTH-1:0] iter_lo;

  // One iteration: whi/wlo hold {P_hi, P_lo} for MULTU and {R, Q} for DIVU
  always_comb begin
    iter_hi   = whi_q;
    iter_lo   = wlo_q;
    mul_sum   = whi_q + (wlo_q[0] ? {1'b0, opa_q} : '0);
    div_shift = {whi_q[WIDTH-1:0], wlo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    if (op_q) begin
      if (div_shift >= {1'b0, opb_q}) begin
        iter_hi = div_diff;
        iter_lo = {wlo_q[WIDTH-2:0], 1'b1};
      end else begin
        iter_hi = div_shift;
        iter_lo = {wlo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      iter_hi = {1'b0, mul_sum[WIDTH:1]};
      iter_lo = {mul_sum[0], wlo_q[WIDTH-1:1]};
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    whi_d   = whi_q;
    wlo_d   = wlo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          op_d    = op;
          opa_d   = a;
          opb_d   = b;
          whi_d   = '0;
          wlo_d   = op ? a : b;
          count_d = CW'(WIDTH);
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        whi_d   = iter_hi;
        wlo_d   = iter_lo;
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          // Divide by zero: quotient all ones, remainder is the dividend
          if (op_q && (opb_q == '0)) begin
            hi_d = opa_q;
            lo_d = '1;
          end else begin
            hi_d = iter_hi[WIDTH-1:0];
            lo_d = iter_lo;
          end
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      op_q    <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      whi_q   <= '0;
      wlo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      whi_q   <= whi_d;
      wlo_q   <= wlo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: transaction-level reference model checked every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_mult_div_unit;

  localparam int unsigned W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, got, want);
  endtask

  // Architectural result as {HI, LO}
  function automatic logic [2*W-1:0] ref_result(input logic op_i, input logic [W-1:0] x,
                                                input logic [W-1:0] y);
    if (!op_i) return (2*W)'(x) * (2*W)'(y);
    if (y == '0) return {x, {W{1'b1}}};
    return {x % y, x / y};
  endfunction

  // Model: an accepted request lands W edges later; requests are ignored while one is pending
  int             m_left;
  logic           m_done;
  logic [W-1:0]   m_hi;
  logic [W-1:0]   m_lo;
  logic [2*W-1:0] m_pend;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_pend <= '0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      m_done <= (m_left == 1);
      if (m_left == 1) begin
        m_hi <= m_pend[2*W-1:W];
        m_lo <= m_pend[W-1:0];
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_pend <= ref_result(op, a, b);
        m_left <= W;
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en && !reset) begin
      check("model_busy", 64'(busy), 64'(m_left != 0));
      check("model_done", 64'(done), 64'(m_done));
      check("model_hi", 64'(hi), 64'(m_hi));
      check("model_lo", 64'(lo), 64'(m_lo));
    end
  end

  task automatic start_op(input logic op_i, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    op    = op_i;
    a     = x;
    b     = y;
  endtask

  // Called on the negedge where start is driven; returns on the negedge that shows done
  task automatic wait_done(output int cyc, output int nbusy);
    cyc   = 0;
    nbusy = 0;
    do begin
      @(negedge clock);
      if (cyc == 0) start = 1'b0;
      cyc++;
      if (busy) nbusy++;
    end while (!done && cyc < 60);
    if (!done) check("done_timeout", 64'(done), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int cyc;
    int nbusy;
    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clock);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    reset  = 1'b0;
    cmp_en = 1'b1;
    @(negedge clock);

    // MULTU max * max
    start_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc, nbusy);
    check("mul_max_latency", 64'(cyc), 64'd33);
    check("mul_max_busy_cycles", 64'(nbusy), 64'd32);
    check("mul_max_hi", 64'(hi), 64'hFFFF_FFFE);
    check("mul_max_lo", 64'(lo), 64'h0000_0001);
    @(negedge clock);
    check("done_one_cycle", 64'(done), 64'd0);

    // DIVU 100 / 7
    start_op(1'b1, 32'd100, 32'd7);
    wait_done(cyc, nbusy);
    check("div_100_7_hi", 64'(hi), 64'd2);
    check("div_100_7_lo", 64'(lo), 64'd14);
    @(negedge clock);

    // DIVU 0x80000000 / 0xFFFFFFFF
    start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc, nbusy);
    check("div_big_hi", 64'(hi), 64'h8000_0000);
    check("div_big_lo", 64'(lo), 64'd0);
    @(negedge clock);

    // DIVU by zero
    start_op(1'b1, 32'h1234_5678, 32'd0);
    wait_done(cyc, nbusy);
    check("div0_latency", 64'(cyc), 64'd33);
    check("div0_hi", 64'(hi), 64'h1234_5678);
    check("div0_lo", 64'(lo), 64'hFFFF_FFFF);
    @(negedge clock);
    check("div0_single_done", 64'(done), 64'd0);

    // MULTU 3*5 with a second request and operand changes during RUN
    start_op(1'b0, 32'd3, 32'd5);
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
      case (cyc)
        1:  start = 1'b0;
        10: start_op(1'b1, 32'd9, 32'd2);
        11: begin a = 32'd77; b = 32'd0; end
        13: start = 1'b0;
        default: ;
      endcase
      if (cyc == 20) begin
        check("stale_hi_in_run", 64'(hi), 64'h1234_5678);
        check("stale_lo_in_run", 64'(lo), 64'hFFFF_FFFF);
      end
    end while (!done && cyc < 60);
    check("ignore_latency", 64'(cyc), 64'd33);
    check("ignore_hi", 64'(hi), 64'd0);
    check("ignore_lo", 64'(lo), 64'd15);
    @(negedge clock);

    // Reset in the middle of a MULTU
    start_op(1'b0, 32'hDEAD_BEEF, 32'h0000_1234);
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) start = 1'b0;
    end while (cyc < 16);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (20) begin
      @(negedge clock);
      check("no_done_after_abort", 64'(done), 64'd0);
    end
    start_op(1'b0, 32'h0001_0000, 32'h0001_0000);
    wait_done(cyc, nbusy);
    check("post_reset_latency", 64'(cyc), 64'd33);
    check("post_reset_hi", 64'(hi), 64'd1);
    check("post_reset_lo", 64'(lo), 64'd0);
    @(negedge clock);

    // DIVU 50/5 then MULTU 6*7 issued in the done cycle
    start_op(1'b1, 32'd50, 32'd5);
    wait_done(cyc, nbusy);
    check("b2b_div_hi", 64'(hi), 64'd0);
    check("b2b_div_lo", 64'(lo), 64'd10);
    start_op(1'b0, 32'd6, 32'd7);
    wait_done(cyc, nbusy);
    check("b2b_mul_latency", 64'(cyc), 64'd33);
    check("b2b_mul_busy_cycles", 64'(nbusy), 64'd32);
    check("b2b_mul_hi", 64'(hi), 64'd0);
    check("b2b_mul_lo", 64'(lo), 64'd42);
    repeat (2) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
